// File: rtl/mul_pkg.sv
// Shared definitions for the MUL issuer: FSM state encoding, operand/product widths, default watchdog limit.
package mul_pkg;

  localparam int OPND_W             = 32;
  localparam int RES_W              = 64;
  localparam int DEF_TIMEOUT_CYCLES = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CLEAR = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mul_watchdog.sv
// Resettable up-counter whose terminal-count flag fires on the TIMEOUT_CYCLES-th enabled cycle after clr.
// Latency: tc is combinational from the count; clr wins over en; the count holds once tc is reached.
module mul_watchdog #(
  parameter int TIMEOUT_CYCLES = mul_pkg::DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mul_issuer.sv
// Drives one MUL op per accepted operand pair; op_start from the cycle after accept, response two cycles after op_done.
// Backpressure: req_ready only in IDLE, so a stalled response blocks new requests; abort in ISSUE drops the op silently.
module mul_issuer
  import mul_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OPND_W-1:0] req_multiplier,
  input  logic [OPND_W-1:0] req_multiplicand,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_err,
  input  logic              abort,
  output logic [OPND_W-1:0] multiplier,
  output logic [OPND_W-1:0] multiplicand,
  output logic              op_start,
  output logic              op_clear,
  input  logic              op_done,
  input  logic [RES_W-1:0]  result,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_e state_q, state_d;
  logic   drop;
  logic   accept, ev_abort, ev_done, ev_to;
  logic   wd_tc;

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  mul_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (accept),
    .en     (state_q == ST_ISSUE),
    .tc     (wd_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ISSUE exit priority: abort, then op_done, then watchdog expiry.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    ev_abort = 1'b0;
    ev_done  = 1'b0;
    ev_to    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          ev_abort = 1'b1;
          state_d  = ST_CLEAR;
        end else if (op_done) begin
          ev_done = 1'b1;
          state_d = ST_CLEAR;
        end else if (wd_tc) begin
          ev_to   = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = drop ? ST_IDLE : ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      multiplier   <= '0;
      multiplicand <= '0;
      op_start     <= 1'b0;
      op_clear     <= 1'b0;
      drop         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_err      <= 1'b0;
      op_count     <= '0;
    end else begin
      op_clear <= ev_abort | ev_done | ev_to;
      if (accept) begin
        multiplier   <= req_multiplier;
        multiplicand <= req_multiplicand;
        op_start     <= 1'b1;
        drop         <= 1'b0;
      end
      if (ev_abort | ev_done | ev_to) op_start <= 1'b0;
      if (ev_abort) drop <= 1'b1;
      if (ev_done) begin
        rsp_result <= result;
        rsp_err    <= 1'b0;
      end
      if (ev_to) begin
        rsp_result <= '0;
        rsp_err    <= 1'b1;
      end
      if (state_q == ST_CLEAR) begin
        rsp_valid <= !drop;
        if (!drop && !rsp_err) op_count <= op_count + CNT_W'(1);
      end
      if (state_q == ST_RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_issuer.sv
// Bench for mul_issuer: behavioural signed MUL with variable latency on the main instance, and a
// second instance (16-cycle watchdog) wired to a MUL that never finishes.
module tb_mul_issuer;

  localparam int CNT_W     = 16;
  localparam int T_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_multiplier = '0;
  logic [31:0]       req_multiplicand = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [63:0]       rsp_result;
  logic              rsp_err;
  logic              abort = 1'b0;
  logic [31:0]       multiplier, multiplicand;
  logic              op_start, op_clear, op_done;
  logic [63:0]       result;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  logic              req_valid_t = 1'b0;
  logic              req_ready_t, rsp_valid_t, rsp_err_t, op_start_t, op_clear_t, busy_t;
  logic              rsp_ready_t = 1'b0;
  logic              abort_t = 1'b0;
  logic              op_done_t = 1'b0;
  logic [63:0]       result_t = 64'hDEAD_BEEF_CAFE_F00D;
  logic [63:0]       rsp_result_t;
  logic [31:0]       multiplier_t, multiplicand_t;
  logic [CNT_W-1:0]  op_count_t;

  mul_issuer #(.TIMEOUT_CYCLES(128), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_multiplier(req_multiplier), .req_multiplicand(req_multiplicand),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .abort(abort), .multiplier(multiplier), .multiplicand(multiplicand),
    .op_start(op_start), .op_clear(op_clear), .op_done(op_done), .result(result),
    .busy(busy), .op_count(op_count)
  );

  mul_issuer #(.TIMEOUT_CYCLES(T_TIMEOUT), .CNT_W(CNT_W)) dut_t (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid_t), .req_ready(req_ready_t),
    .req_multiplier(req_multiplier), .req_multiplicand(req_multiplicand),
    .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready_t), .rsp_result(rsp_result_t), .rsp_err(rsp_err_t),
    .abort(abort_t), .multiplier(multiplier_t), .multiplicand(multiplicand_t),
    .op_start(op_start_t), .op_clear(op_clear_t), .op_done(op_done_t), .result(result_t),
    .busy(busy_t), .op_count(op_count_t)
  );

  int total = 0;
  int bad = 0;
  int exp_count = 0;
  int mul_lat = 3;
  int proto_err = 0;
  int overlap = 0;
  int clr_pulses = 0;

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Behavioural MUL: starts on a rising op_start, finishes mul_lat cycles later, holds op_done until op_clear.
  logic        m_run, m_done, m_cleared, m_prev_start;
  logic [63:0] m_res;
  int          m_cnt;
  assign op_done = m_done;
  assign result  = m_res;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run <= 1'b0; m_done <= 1'b0; m_res <= '0; m_cnt <= 0;
      m_cleared <= 1'b1; m_prev_start <= 1'b0;
    end else begin
      m_prev_start <= op_start;
      if (op_clear) begin
        m_run <= 1'b0; m_done <= 1'b0; m_cleared <= 1'b1;
      end else if (op_start && !m_run) begin
        if (!m_cleared && !m_prev_start) proto_err <= proto_err + 1;
        m_run <= 1'b1; m_cnt <= 0; m_cleared <= 1'b0;
      end else if (m_run && !m_done) begin
        if (m_cnt == mul_lat - 1) begin
          m_done <= 1'b1;
          m_res  <= prod(multiplier, multiplicand);
        end
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (op_clear) clr_pulses <= clr_pulses + 1;
    if (op_start && rsp_valid) overlap <= overlap + 1;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL issue_wait: req_ready=%b required 1 within 100 cycles", req_ready);
    end else begin
      req_multiplier = a; req_multiplicand = b; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic get_rsp(input int bp, output logic [63:0] r, output logic e,
                         output logic [CNT_W-1:0] c);
    int n = 0;
    r = '0; e = 1'b0; c = '0;
    rsp_ready = (bp == 0);
    while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
    total++;
    if (!rsp_valid) begin
      bad++;
      rsp_ready = 1'b0;
      $display("FAIL rsp_wait: rsp_valid=0 required 1 within 400 cycles");
    end else begin
      r = rsp_result; e = rsp_err; c = op_count;
      repeat (bp) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({op_start, op_clear, rsp_valid, rsp_err, busy, req_ready} !== 6'b000001) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000001", {op_start, op_clear, rsp_valid, rsp_err, busy, req_ready});
    end
    total++;
    if ({multiplier, multiplicand, rsp_result} !== 128'd0) begin
      bad++; $display("FAIL reset_data: got %h/%h/%h want zeros", multiplier, multiplicand, rsp_result);
    end
    total++;
    if (op_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", op_count); end
    total++;
    if ({op_start_t, rsp_valid_t, busy_t, req_ready_t} !== 4'b0001) begin
      bad++; $display("FAIL reset_t: got %b want 0001", {op_start_t, rsp_valid_t, busy_t, req_ready_t});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n = 0;
    int clr0;
    mul_lat = 3;
    rsp_ready = 1'b1;
    issue(32'd3, 32'd5);
    clr0 = clr_pulses;
    total++;
    if ({op_start, busy, req_ready, multiplier, multiplicand} !== {3'b110, 32'd3, 32'd5}) begin
      bad++; $display("FAIL basic_issue: got start/busy/rdy=%b op=%h*%h want 110 3*5",
                      {op_start, busy, req_ready}, multiplier, multiplicand);
    end
    while (!op_done && n < 100) begin @(negedge clk); n++; end
    total++;
    if (!op_done) begin bad++; $display("FAIL basic_done_wait: op_done=0 required 1"); end
    @(negedge clk);
    total++;
    if ({op_clear, op_start, rsp_valid} !== 3'b100) begin
      bad++; $display("FAIL basic_clear: clr/start/vld got %b want 100", {op_clear, op_start, rsp_valid});
    end
    @(negedge clk);
    exp_count++;
    total++;
    if ({op_clear, rsp_valid, rsp_err} !== 3'b010 || rsp_result !== 64'h0000_0000_0000_000F) begin
      bad++; $display("FAIL basic_rsp: clr/vld/err=%b result=%h want 010 000000000000000f",
                      {op_clear, rsp_valid, rsp_err}, rsp_result);
    end
    total++;
    if (op_count !== CNT_W'(exp_count)) begin
      bad++; $display("FAIL basic_count: got %0d want %0d", op_count, exp_count);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, busy, req_ready} !== 3'b001) begin
      bad++; $display("FAIL basic_idle: vld/busy/rdy got %b want 001", {rsp_valid, busy, req_ready});
    end
    total++;
    if (clr_pulses - clr0 !== 1) begin
      bad++; $display("FAIL basic_clear_pulses: got %0d want 1", clr_pulses - clr0);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    logic e;
    logic [CNT_W-1:0] c;
    mul_lat = 2;
    overlap = 0;
    issue(32'hFFFF_FFFD, 32'd5);
    get_rsp(0, r, e, c);
    exp_count++;
    total++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFF1 || e !== 1'b0 || c !== CNT_W'(exp_count)) begin
      bad++; $display("FAIL b2b_first: result=%h err=%b cnt=%0d want fffffffffffffff1 0 %0d", r, e, c, exp_count);
    end
    issue(32'd3, 32'hFFFF_FFFE);
    get_rsp(0, r, e, c);
    exp_count++;
    total++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFA || e !== 1'b0 || c !== CNT_W'(exp_count)) begin
      bad++; $display("FAIL b2b_second: result=%h err=%b cnt=%0d want fffffffffffffffa 0 %0d", r, e, c, exp_count);
    end
    total++;
    if (overlap !== 0) begin
      bad++; $display("FAIL b2b_overlap: op_start during rsp_valid for %0d cycles, want 0", overlap);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    mul_lat = 4;
    rsp_ready = 1'b0;
    issue(32'd7, 32'd0);
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    exp_count++;
    for (int i = 0; i < 20; i++) begin
      total++;
      if ({rsp_valid, req_ready, rsp_result} !== {1'b1, 1'b0, 64'd0}) begin
        bad++; $display("FAIL bp_hold[%0d]: vld=%b rdy=%b result=%h want 1 0 0", i, rsp_valid, req_ready, rsp_result);
      end
      @(negedge clk);
    end
    total++;
    if (op_count !== CNT_W'(exp_count)) begin
      bad++; $display("FAIL bp_count: got %0d want %0d", op_count, exp_count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, busy, req_ready} !== 3'b001) begin
      bad++; $display("FAIL bp_release: vld/busy/rdy got %b want 001", {rsp_valid, busy, req_ready});
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    req_multiplier = 32'd11; req_multiplicand = 32'd13; req_valid_t = 1'b1;
    @(negedge clk);
    req_valid_t = 1'b0;
    while (op_start_t && n < 200) begin n++; @(negedge clk); end
    total++;
    if (n !== T_TIMEOUT) begin
      bad++; $display("FAIL to_start_cycles: op_start held %0d cycles want %0d", n, T_TIMEOUT);
    end
    total++;
    if ({op_clear_t, op_start_t, rsp_valid_t} !== 3'b100) begin
      bad++; $display("FAIL to_clear: clr/start/vld got %b want 100", {op_clear_t, op_start_t, rsp_valid_t});
    end
    @(negedge clk);
    total++;
    if ({rsp_valid_t, rsp_err_t} !== 2'b11 || rsp_result_t !== 64'd0 || op_count_t !== '0) begin
      bad++; $display("FAIL to_rsp: vld/err=%b result=%h cnt=%0d want 11 0 0",
                      {rsp_valid_t, rsp_err_t}, rsp_result_t, op_count_t);
    end
    rsp_ready_t = 1'b1;
    @(negedge clk);
    rsp_ready_t = 1'b0;
    total++;
    if ({busy_t, req_ready_t, rsp_valid_t} !== 3'b010) begin
      bad++; $display("FAIL to_idle: busy/rdy/vld got %b want 010", {busy_t, req_ready_t, rsp_valid_t});
    end
  endtask

  task automatic test_abort();
    int n = 0;
    int seen = 0;
    logic [63:0] r;
    logic e;
    logic [CNT_W-1:0] c;
    mul_lat = 100;
    issue(32'd3, 32'd5);
    repeat (29) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({op_clear, op_start, rsp_valid} !== 3'b100) begin
      bad++; $display("FAIL abort_clear: clr/start/vld got %b want 100", {op_clear, op_start, rsp_valid});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    total++;
    if (seen !== 0 || op_count !== CNT_W'(exp_count)) begin
      bad++; $display("FAIL abort_idle: busy/valid cycles=%0d cnt=%0d want 0 %0d", seen, op_count, exp_count);
    end
    mul_lat = 4;
    issue(32'd3, 32'd5);
    while (!op_done && n < 100) begin @(negedge clk); n++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({op_clear, rsp_valid} !== 2'b10) begin
      bad++; $display("FAIL abort_coinc_clear: clr/vld got %b want 10", {op_clear, rsp_valid});
    end
    @(negedge clk);
    total++;
    if ({busy, rsp_valid} !== 2'b00 || op_count !== CNT_W'(exp_count)) begin
      bad++; $display("FAIL abort_coinc_idle: busy/vld=%b cnt=%0d want 00 %0d", {busy, rsp_valid}, op_count, exp_count);
    end
    mul_lat = 3;
    issue(32'd3, 32'd5);
    get_rsp(1, r, e, c);
    exp_count++;
    total++;
    if (r !== 64'hF || e !== 1'b0 || c !== CNT_W'(exp_count)) begin
      bad++; $display("FAIL abort_next: result=%h err=%b cnt=%0d want f 0 %0d", r, e, c, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r;
    logic e;
    logic [CNT_W-1:0] c;
    mul_lat = 50;
    issue(32'd9, 32'd9);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    exp_count = 0;
    total++;
    if ({op_start, op_clear, rsp_valid, rsp_err, busy, req_ready} !== 6'b000001) begin
      bad++; $display("FAIL rst_mid_ctrl: got %b want 000001", {op_start, op_clear, rsp_valid, rsp_err, busy, req_ready});
    end
    total++;
    if ({multiplier, multiplicand} !== 64'd0 || op_count !== '0) begin
      bad++; $display("FAIL rst_mid_data: op=%h*%h cnt=%0d want 0 0 0", multiplier, multiplicand, op_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mul_lat = 3;
    issue(32'd7, 32'd9);
    get_rsp(2, r, e, c);
    exp_count++;
    total++;
    if (r !== 64'd63 || e !== 1'b0 || c !== CNT_W'(exp_count)) begin
      bad++; $display("FAIL rst_mid_after: result=%h err=%b cnt=%0d want 3f 0 %0d", r, e, c, exp_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [63:0] r;
    logic e;
    logic [CNT_W-1:0] c;
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      b = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
      mul_lat = $urandom_range(1, 12);
      issue(a, b);
      get_rsp($urandom_range(0, 3), r, e, c);
      exp_count++;
      total++;
      if (r !== prod(a, b) || e !== 1'b0 || c !== CNT_W'(exp_count)) begin
        bad++; $display("FAIL rand[%0d] %h*%h: result=%h err=%b cnt=%0d want %h 0 %0d",
                        i, a, b, r, e, c, prod(a, b), exp_count);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout: bench did not finish within 50000 cycles");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_abort();
    test_random();
    test_reset_mid();
    total++;
    if (proto_err !== 0) begin
      bad++; $display("FAIL mul_start_without_clear: got %0d want 0", proto_err);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
